// File: rtl/ahbl_master_arbiter.sv
// Round-robin arbiter that shares one AHB-Lite master port between NREQ single-beat requesters.
// One transfer in flight at a time: IDLE -> ADDR (NONSEQ) -> DATA -> ACK back to the winner.
module ahbl_master_arbiter #(
    parameter int NREQ     = 4,
    parameter int WAIT_MAX = 1024
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ-1:0]    REQ_WRITE,
    input  logic [32*NREQ-1:0] REQ_ADDR,
    input  logic [3*NREQ-1:0]  REQ_SIZE,
    input  logic [32*NREQ-1:0] REQ_WDATA,
    output logic [NREQ-1:0]    ACK,
    output logic [31:0]        RDATA,
    output logic               ERR,
    output logic               HANG,
    output logic [31:0]        HADDR,
    output logic [1:0]         HTRANS,
    output logic               HWRITE,
    output logic [2:0]         HSIZE,
    output logic [2:0]         HBURST,
    output logic [3:0]         HPROT,
    output logic               HMASTLOCK,
    output logic [31:0]        HWDATA,
    input  logic [31:0]        HRDATA,
    input  logic               HREADY,
    input  logic               HRESP
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [IW-1:0]   ptr_r, ptr_s;
    logic [IW-1:0]   idx_r, idx_s;
    logic [15:0]     wait_cnt_r, wait_cnt_s;
    logic [31:0]     haddr_r, haddr_s;
    logic [1:0]      htrans_r, htrans_s;
    logic            hwrite_r, hwrite_s;
    logic [2:0]      hsize_r, hsize_s;
    logic [31:0]     hwdata_r, hwdata_s;
    logic [NREQ-1:0] ack_r, ack_s;
    logic [31:0]     rdata_r, rdata_s;
    logic            err_r, err_s;
    logic            hang_r, hang_s;
    logic            gnt_valid_s;
    logic [IW-1:0]   gnt_idx_s;
    logic [IW-1:0]   cand_s;

    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign HADDR     = haddr_r;
    assign HTRANS    = htrans_r;
    assign HWRITE    = hwrite_r;
    assign HSIZE     = hsize_r;
    assign HWDATA    = hwdata_r;
    assign ACK       = ack_r;
    assign RDATA     = rdata_r;
    assign ERR       = err_r;
    assign HANG      = hang_r;

    // Round-robin winner: first set REQ bit scanning upward from ptr with wrap.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        for (int j = 0; j < NREQ; j++) begin
            cand_s      = IW'((int'(ptr_r) + j) % NREQ);
            gnt_idx_s   = (!gnt_valid_s && REQ[cand_s]) ? cand_s : gnt_idx_s;
            gnt_valid_s = gnt_valid_s | REQ[cand_s];
        end
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        idx_s      = idx_r;
        wait_cnt_s = wait_cnt_r;
        haddr_s    = haddr_r;
        htrans_s   = TR_IDLE;
        hwrite_s   = hwrite_r;
        hsize_s    = hsize_r;
        hwdata_s   = hwdata_r;
        ack_s      = '0;
        rdata_s    = rdata_r;
        err_s      = 1'b0;
        hang_s     = hang_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_s    = ST_ADDR;
                    idx_s      = gnt_idx_s;
                    htrans_s   = TR_NONSEQ;
                    haddr_s    = REQ_ADDR[32*int'(gnt_idx_s) +: 32];
                    hwrite_s   = REQ_WRITE[gnt_idx_s];
                    hsize_s    = REQ_SIZE[3*int'(gnt_idx_s) +: 3];
                    wait_cnt_s = 16'd0;
                    hwdata_s   = REQ_WRITE[gnt_idx_s] ? REQ_WDATA[32*int'(gnt_idx_s) +: 32] : hwdata_r;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // HREADY low here is the tail of someone else's data phase on the bus.
                if (HREADY) begin
                    state_s  = ST_DATA;
                    htrans_s = TR_IDLE;
                end else begin
                    htrans_s = TR_NONSEQ;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_s      = ST_IDLE;
                    ack_s[idx_r] = 1'b1;
                    rdata_s      = hwrite_r ? rdata_r : HRDATA;
                    err_s        = HRESP;
                    ptr_s        = (idx_r == IW'(NREQ - 1)) ? '0 : IW'(idx_r + 1'b1);
                end else begin
                    wait_cnt_s = (wait_cnt_r == 16'hFFFF) ? wait_cnt_r : wait_cnt_r + 16'd1;
                    hang_s     = (({1'b0, wait_cnt_r} + 17'd1) >= 17'(WAIT_MAX)) ? 1'b1 : hang_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            idx_r      <= '0;
            wait_cnt_r <= 16'd0;
            haddr_r    <= 32'd0;
            htrans_r   <= TR_IDLE;
            hwrite_r   <= 1'b0;
            hsize_r    <= 3'b000;
            hwdata_r   <= 32'd0;
            ack_r      <= '0;
            rdata_r    <= 32'd0;
            err_r      <= 1'b0;
            hang_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            idx_r      <= idx_s;
            wait_cnt_r <= wait_cnt_s;
            haddr_r    <= haddr_s;
            htrans_r   <= htrans_s;
            hwrite_r   <= hwrite_s;
            hsize_r    <= hsize_s;
            hwdata_r   <= hwdata_s;
            ack_r      <= ack_s;
            rdata_r    <= rdata_s;
            err_r      <= err_s;
            hang_r     <= hang_s;
        end
    end

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Directed bench for ahbl_master_arbiter: cycle table for single transfers, hand sequences for
// round-robin, hang detection and reset during a data phase.
module tb_ahbl_master_arbiter;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [3:0]   REQ;
    logic [3:0]   REQ_WRITE;
    logic [127:0] REQ_ADDR;
    logic [11:0]  REQ_SIZE;
    logic [127:0] REQ_WDATA;
    logic [3:0]   ACK;
    logic [31:0]  RDATA;
    logic         ERR;
    logic         HANG;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HSIZE;
    logic [2:0]   HBURST;
    logic [3:0]   HPROT;
    logic         HMASTLOCK;
    logic [31:0]  HWDATA;
    logic [31:0]  HRDATA;
    logic         HREADY;
    logic         HRESP;

    int errors = 0;
    int checks = 0;

    ahbl_master_arbiter #(.NREQ(4), .WAIT_MAX(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .REQ(REQ), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
        .REQ_SIZE(REQ_SIZE), .REQ_WDATA(REQ_WDATA), .ACK(ACK), .RDATA(RDATA), .ERR(ERR),
        .HANG(HANG), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [3:0]  req;
        logic        hready;
        logic        hresp;
        logic [31:0] hrdata;
        logic [1:0]  e_htrans;
        logic [31:0] e_haddr;
        logic        e_hwrite;
        logic [2:0]  e_hsize;
        logic [3:0]  e_ack;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        chk_wd;
        logic [31:0] e_hwdata;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] addr_tbl[4];
    logic        wr_tbl[4];
    logic [31:0] exp_rdata;
    logic [31:0] rd_val;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        addr_tbl = '{32'h0000_0100, 32'h0000_BAD0, 32'h0000_0024, 32'h0000_0300};
        wr_tbl   = '{1'b0, 1'b0, 1'b1, 1'b0};
        REQ_WRITE = 4'b0100;
        REQ_ADDR  = {addr_tbl[3], addr_tbl[2], addr_tbl[1], addr_tbl[0]};
        REQ_SIZE  = {3'b001, 3'b010, 3'b010, 3'b010};
        REQ_WDATA = {32'd0, 32'h1234_5678, 32'd0, 32'd0};
        REQ = 4'b0000; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
        HRESET = 1'b1;
        tick(); tick();
        chk("rst htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst haddr", HADDR, 32'd0);
        chk("rst hwrite", {31'd0, HWRITE}, 32'd0);
        chk("rst hsize", {29'd0, HSIZE}, 32'd0);
        chk("rst hwdata", HWDATA, 32'd0);
        chk("rst ack", {28'd0, ACK}, 32'd0);
        chk("rst rdata", RDATA, 32'd0);
        chk("rst err", {31'd0, ERR}, 32'd0);
        chk("rst hang", {31'd0, HANG}, 32'd0);
        chk("hburst", {29'd0, HBURST}, 32'd0);
        chk("hprot", {28'd0, HPROT}, 32'd3);
        chk("hmastlock", {31'd0, HMASTLOCK}, 32'd0);
        HRESET = 1'b0;

        // req0 read 0x100, zero wait
        vecs.push_back('{4'b0001, 1'b1, 1'b0, 32'hFFFF_0000, 2'b10, 32'h100, 1'b0, 3'b010, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{4'b0001, 1'b1, 1'b0, 32'hFFFF_0000, 2'b00, 32'h100, 1'b0, 3'b010, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{4'b0001, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'h100, 1'b0, 3'b010, 4'b0001, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{4'b0000, 1'b1, 1'b0, 32'h0, 2'b00, 32'h100, 1'b0, 3'b010, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0});
        // req2 write 0x24, three wait states
        vecs.push_back('{4'b0100, 1'b1, 1'b0, 32'h0, 2'b10, 32'h24, 1'b1, 3'b010, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{4'b0100, 1'b1, 1'b0, 32'h0, 2'b00, 32'h24, 1'b1, 3'b010, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h1234_5678});
        for (int k = 0; k < 3; k++)
            vecs.push_back('{4'b0100, 1'b0, 1'b0, 32'h0, 2'b00, 32'h24, 1'b1, 3'b010, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h1234_5678});
        vecs.push_back('{4'b0100, 1'b1, 1'b0, 32'hCAFE_F00D, 2'b00, 32'h24, 1'b1, 3'b010, 4'b0100, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h1234_5678});
        vecs.push_back('{4'b0000, 1'b1, 1'b0, 32'h0, 2'b00, 32'h24, 1'b1, 3'b010, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0});
        // req1 read 0xBAD0, two-cycle ERROR
        vecs.push_back('{4'b0010, 1'b1, 1'b0, 32'h0, 2'b10, 32'hBAD0, 1'b0, 3'b010, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{4'b0010, 1'b1, 1'b0, 32'h0, 2'b00, 32'hBAD0, 1'b0, 3'b010, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{4'b0010, 1'b0, 1'b1, 32'h0, 2'b00, 32'hBAD0, 1'b0, 3'b010, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{4'b0010, 1'b1, 1'b1, 32'h0000_0BAD, 2'b00, 32'hBAD0, 1'b0, 3'b010, 4'b0010, 32'h0000_0BAD, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{4'b0000, 1'b1, 1'b0, 32'h0, 2'b00, 32'hBAD0, 1'b0, 3'b010, 4'b0000, 32'h0000_0BAD, 1'b0, 1'b0, 32'h0});
        // req3 read 0x300 halfword, clean response after the error
        vecs.push_back('{4'b1000, 1'b1, 1'b0, 32'h0, 2'b10, 32'h300, 1'b0, 3'b001, 4'b0000, 32'h0000_0BAD, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{4'b1000, 1'b1, 1'b0, 32'h0, 2'b00, 32'h300, 1'b0, 3'b001, 4'b0000, 32'h0000_0BAD, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{4'b1000, 1'b1, 1'b0, 32'h55AA_55AA, 2'b00, 32'h300, 1'b0, 3'b001, 4'b1000, 32'h55AA_55AA, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{4'b0000, 1'b1, 1'b0, 32'h0, 2'b00, 32'h300, 1'b0, 3'b001, 4'b0000, 32'h55AA_55AA, 1'b0, 1'b0, 32'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            REQ = vecs[i].req; HREADY = vecs[i].hready; HRESP = vecs[i].hresp; HRDATA = vecs[i].hrdata;
            tick();
            chk($sformatf("v%0d htrans", i), {30'd0, HTRANS}, {30'd0, vecs[i].e_htrans});
            chk($sformatf("v%0d haddr", i), HADDR, vecs[i].e_haddr);
            chk($sformatf("v%0d hwrite", i), {31'd0, HWRITE}, {31'd0, vecs[i].e_hwrite});
            chk($sformatf("v%0d hsize", i), {29'd0, HSIZE}, {29'd0, vecs[i].e_hsize});
            chk($sformatf("v%0d ack", i), {28'd0, ACK}, {28'd0, vecs[i].e_ack});
            chk($sformatf("v%0d rdata", i), RDATA, vecs[i].e_rdata);
            chk($sformatf("v%0d err", i), {31'd0, ERR}, {31'd0, vecs[i].e_err});
            if (vecs[i].chk_wd) chk($sformatf("v%0d hwdata", i), HWDATA, vecs[i].e_hwdata);
        end

        // all four requesting: grant order 0,1,2,3,0,1,2,3 back to back
        exp_rdata = 32'h55AA_55AA;
        HRESP = 1'b0; HREADY = 1'b1;
        for (int t = 0; t < 8; t++) begin
            REQ = 4'b1111; HRDATA = 32'd0;
            tick();
            chk($sformatf("rr%0d htrans", t), {30'd0, HTRANS}, 32'd2);
            chk($sformatf("rr%0d haddr", t), HADDR, addr_tbl[t % 4]);
            tick();
            rd_val = 32'hA000_0000 + 32'(t);
            HRDATA = rd_val;
            tick();
            chk($sformatf("rr%0d ack", t), {28'd0, ACK}, 32'd1 << (t % 4));
            if (!wr_tbl[t % 4]) exp_rdata = rd_val;
            chk($sformatf("rr%0d rdata", t), RDATA, exp_rdata);
        end
        REQ = 4'b0000;
        tick();
        chk("rr end ack", {28'd0, ACK}, 32'd0);

        // data phase stalled for 10 cycles with WAIT_MAX=4
        REQ = 4'b0001; HREADY = 1'b1;
        tick(); tick();
        HREADY = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("hang w%0d", k), {31'd0, HANG}, (k >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("hang w%0d ack", k), {28'd0, ACK}, 32'd0);
        end
        HREADY = 1'b1; HRDATA = 32'h0000_0077;
        tick();
        chk("hang ack", {28'd0, ACK}, 32'd1);
        chk("hang rdata", RDATA, 32'h0000_0077);
        chk("hang at ack", {31'd0, HANG}, 32'd1);
        REQ = 4'b0000;
        tick();
        chk("hang sticky", {31'd0, HANG}, 32'd1);

        // reset during a stalled data phase of requester 1
        REQ = 4'b0010;
        tick();
        chk("mid haddr", HADDR, 32'hBAD0);
        tick();
        HREADY = 1'b0;
        tick();
        HRESET = 1'b1;
        tick();
        chk("mid rst htrans", {30'd0, HTRANS}, 32'd0);
        chk("mid rst ack", {28'd0, ACK}, 32'd0);
        chk("mid rst hang", {31'd0, HANG}, 32'd0);
        chk("mid rst haddr", HADDR, 32'd0);
        HRESET = 1'b0; REQ = 4'b0000; HREADY = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("post rst%0d ack", k), {28'd0, ACK}, 32'd0);
            chk($sformatf("post rst%0d htrans", k), {30'd0, HTRANS}, 32'd0);
        end
        REQ = 4'b1001;
        tick();
        chk("ptr0 haddr", HADDR, 32'h100);
        tick();
        HRDATA = 32'h2468_ACE0;
        tick();
        chk("ptr0 ack", {28'd0, ACK}, 32'd1);
        chk("ptr0 rdata", RDATA, 32'h2468_ACE0);
        REQ = 4'b0010; HRDATA = 32'd0;
        tick();
        chk("r1 htrans", {30'd0, HTRANS}, 32'd2);
        chk("r1 haddr", HADDR, 32'hBAD0);
        tick();
        HRDATA = 32'h1357_2468;
        tick();
        chk("r1 ack", {28'd0, ACK}, 32'd2);
        chk("r1 rdata", RDATA, 32'h1357_2468);
        chk("r1 err", {31'd0, ERR}, 32'd0);
        REQ = 4'b0000;
        tick();
        chk("r1 end ack", {28'd0, ACK}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahbl_master_arbiter.md
# ahbl_master_arbiter

Shares a single AHB-Lite master port between NREQ local requesters, each issuing single-beat read or write commands. Arbitrates round-robin, sequences the address and data phases, absorbs slave wait states and two-cycle ERROR responses, and returns read data with a per-requester acknowledge. Sits between test/control engines and the AHB-Lite fabric, where the bus-functional master would otherwise sit.

## Interface
- NREQ, 4, number of requesters (2..8)
- WAIT_MAX, 1024, data-phase wait-state count that sets the HANG flag (1..65535)
- HCLK  in  1  clock, all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- REQ  in  NREQ  per-requester command request, level
- REQ_WRITE  in  NREQ  1 = write, 0 = read
- REQ_ADDR  in  32*NREQ  byte address, requester i at [32i+31:32i]
- REQ_SIZE  in  3*NREQ  HSIZE encoding (000/001/010 only)
- REQ_WDATA  in  32*NREQ  write data
- ACK  out  NREQ  one-cycle completion pulse to the owning requester
- RDATA  out  32  read data, valid while ACK is high
- ERR  out  1  high with ACK when the slave returned ERROR
- HANG  out  1  sticky: a data phase exceeded WAIT_MAX wait states
- HADDR  out 32, HTRANS out 2, HWRITE out 1, HSIZE out 3, HBURST out 3, HPROT out 4, HMASTLOCK out 1, HWDATA out 32  AHB-Lite master outputs
- HRDATA  in 32, HREADY in 1, HRESP in 1  AHB-Lite master inputs

## Operation
- Constants: HBURST=000 (SINGLE), HPROT=4'b0011, HMASTLOCK=0.
- States IDLE, ADDR, DATA. One transfer in flight; no pipelining of a new address into a data phase.
- IDLE: HTRANS=00. If any REQ bit set, pick winner by round-robin starting at ptr; latch index, write, addr, size, wdata; go ADDR. Otherwise stay.
- ADDR: HTRANS=10 (NONSEQ), HADDR/HWRITE/HSIZE from latched command. On HREADY=1 go DATA; on HREADY=0 hold (covers a preceding slave stall).
- DATA: HTRANS=00, HWDATA = latched wdata (write) or held. Wait count increments each cycle HREADY=0; reaching WAIT_MAX sets HANG (cleared only by reset). On HREADY=1: capture HRDATA into RDATA (reads only), ERR=HRESP, pulse ACK[index], ptr = index+1 mod NREQ, go IDLE.
- ERROR: first HRESP=1 cycle has HREADY=0 — treated as a wait state; completion on the HREADY=1, HRESP=1 cycle yields ERR=1. No retry.
- Requester holds REQ and operands until it sees ACK. REQ still high in the ACK cycle is a new request.
- Round-robin: ptr resets to 0; winner = first set REQ bit scanning ptr, ptr+1, ... wrapping at NREQ.
- HSIZE 011 or above: passed through unchanged; not checked.

## Timing
- Reset values: state IDLE, ptr 0, HTRANS 00, HADDR 0, HWRITE 0, HSIZE 000, HWDATA 0, ACK 0, RDATA 0, ERR 0, HANG 0, wait count 0.
- All outputs registered.
- Zero-wait latency: REQ sampled at edge E0 -> NONSEQ after E0 -> data phase after E1 -> ACK/RDATA after E2. Three cycles per transfer; back-to-back requests achieve one transfer every 3 cycles.
- Each wait state adds one cycle; ERROR adds the one mandatory wait.
- Reset mid-transfer: returns to IDLE next edge, HTRANS=00, no ACK issued, latched command dropped.
- Simultaneous REQ from all requesters: granted in ptr order, each exactly once per NREQ transfers.

## Test plan
- Single read, req 0, addr 0x100, slave zero-wait returns 0xDEADBEEF -> NONSEQ at HADDR 0x100 one cycle after REQ, ACK[0] three cycles after REQ, RDATA=0xDEADBEEF, ERR=0.
- Write req 2, addr 0x24, data 0x12345678, HSIZE 010, slave inserts 3 wait states -> HWDATA=0x12345678 throughout the data phase, ACK[2] six cycles after REQ.
- All four REQ held high for 8 transfers -> grant order 0,1,2,3,0,1,2,3; ptr wraps correctly.
- Slave ERROR on read of 0xBAD0 (HRESP=1 for 2 cycles, HREADY 0 then 1) -> ACK with ERR=1, next transfer ERR=0.
- WAIT_MAX=4, slave holds HREADY=0 for 10 cycles -> HANG set on 4th wait cycle, stays set after ACK until HRESET.
- HRESET asserted during DATA with HREADY=0 -> next cycle HTRANS=00, ACK never pulses, ptr=0, then a new REQ on 1 proceeds normally.
